// File: rtl/idma_obi_write_burst_issuer.sv
// idma_obi_write_burst_issuer
// Write-side OBI back end for iDMA. Takes one legalized write burst descriptor
// plus its lane-aligned data beats, issues one OBI write per beat with the
// right byte enables, and returns a single burst response once every beat
// has been acknowledged.
// Optional feature: define IDMA_OBI_WRITE_ERR_EN to collect OBI response
// errors into a sticky flag reported on rsp_err_o (otherwise tied to 0).
module idma_obi_write_burst_issuer #(
  parameter int unsigned DataWidth      = 32,
  parameter int unsigned AddrWidth      = 32,
  parameter int unsigned MaxOutstanding = 4,
  localparam int unsigned StrbWidth     = DataWidth / 8,
  localparam int unsigned OffsetWidth   = $clog2(StrbWidth)
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic [AddrWidth-1:0]   req_addr_i,
  input  logic [7:0]             req_num_beats_i,
  input  logic [OffsetWidth-1:0] req_offset_i,
  input  logic [OffsetWidth-1:0] req_tailer_i,
  input  logic                   req_last_i,
  input  logic                   req_valid_i,
  output logic                   req_ready_o,
  input  logic [DataWidth-1:0]   data_i,
  input  logic                   data_valid_i,
  output logic                   data_ready_o,
  output logic                   obi_req_o,
  output logic                   obi_we_o,
  output logic [AddrWidth-1:0]   obi_addr_o,
  output logic [StrbWidth-1:0]   obi_be_o,
  output logic [DataWidth-1:0]   obi_wdata_o,
  input  logic                   obi_gnt_i,
  input  logic                   obi_rvalid_i,
  input  logic                   obi_err_i,
  output logic                   rsp_valid_o,
  input  logic                   rsp_ready_i,
  output logic                   rsp_last_o,
  output logic                   rsp_err_o,
  output logic                   busy_o
);

  localparam int unsigned OutWidth = $clog2(MaxOutstanding + 1);
  localparam logic [OutWidth-1:0]  OutMax   = OutWidth'(MaxOutstanding);
  localparam logic [OutWidth-1:0]  OutOne   = OutWidth'(1);
  localparam logic [AddrWidth-1:0] AddrStep = AddrWidth'(StrbWidth);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] BURST = 2'd1;
  localparam logic [1:0] DRAIN = 2'd2;
  localparam logic [1:0] RESP  = 2'd3;

  logic [1:0]             state_q, state_d;
  logic [AddrWidth-1:0]   addr_q;
  logic [7:0]             beats_left_q;
  logic [OffsetWidth-1:0] offset_q, tailer_q;
  logic                   last_q, first_q, err_q;
  logic [OutWidth-1:0]    outstanding_q, outstanding_d;

  logic                   desc_take, beat_done, rsp_take, final_beat;
  logic [StrbWidth-1:0]   first_mask, last_mask;

  // The low address bits are replaced by zero when the descriptor is latched.
  logic unused_addr_lsb;
  assign unused_addr_lsb = ^req_addr_i[OffsetWidth-1:0];

  assign desc_take  = (state_q == IDLE) & req_valid_i;
  assign final_beat = (beats_left_q == 8'd0);
  assign obi_req_o  = (state_q == BURST) & data_valid_i & (outstanding_q < OutMax);
  assign beat_done  = obi_req_o & obi_gnt_i;
  // Responses only count while a burst owns the bus; strays after a reset are dropped.
  assign rsp_take   = obi_rvalid_i & ((state_q == BURST) | (state_q == DRAIN))
                      & (outstanding_q != '0);

  assign first_mask = {StrbWidth{1'b1}} << offset_q;
  assign last_mask  = (tailer_q == '0) ? {StrbWidth{1'b1}}
                                       : ~({StrbWidth{1'b1}} << tailer_q);

  assign req_ready_o  = (state_q == IDLE);
  assign busy_o       = (state_q != IDLE);
  assign data_ready_o = beat_done;
  assign obi_we_o     = 1'b1;
  assign obi_addr_o   = (state_q == BURST) ? addr_q : '0;
  assign obi_wdata_o  = (state_q == BURST) ? data_i : '0;
  assign rsp_valid_o  = (state_q == RESP);
  assign rsp_last_o   = last_q;
  assign rsp_err_o    = err_q;

  // Byte enables: trim the leading lanes on the first beat and the trailing lanes on the last.
  always_comb begin
    obi_be_o = '0;
    if (state_q == BURST) begin
      obi_be_o = {StrbWidth{1'b1}};
      if (first_q) obi_be_o = obi_be_o & first_mask;
      if (final_beat) obi_be_o = obi_be_o & last_mask;
    end
  end

  // Outstanding count: a grant and a response in the same cycle cancel out.
  always_comb begin
    outstanding_d = outstanding_q;
    if (beat_done && !rsp_take) outstanding_d = outstanding_q + OutOne;
    else if (!beat_done && rsp_take) outstanding_d = outstanding_q - OutOne;
  end

  // Burst sequencing: issue beats, wait for all acks, then hold the response.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (req_valid_i) state_d = BURST;
      BURST:   if (beat_done && final_beat) state_d = DRAIN;
      DRAIN:   if (outstanding_d == '0) state_d = RESP;
      RESP:    if (rsp_ready_i) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State, counters and the latched descriptor fields.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q       <= IDLE;
      outstanding_q <= '0;
      addr_q        <= '0;
      beats_left_q  <= '0;
      offset_q      <= '0;
      tailer_q      <= '0;
      last_q        <= 1'b0;
      first_q       <= 1'b0;
    end else begin
      state_q       <= state_d;
      outstanding_q <= outstanding_d;
      if (desc_take) begin
        addr_q       <= {req_addr_i[AddrWidth-1:OffsetWidth], {OffsetWidth{1'b0}}};
        beats_left_q <= req_num_beats_i;
        offset_q     <= req_offset_i;
        tailer_q     <= req_tailer_i;
        last_q       <= req_last_i;
        first_q      <= 1'b1;
      end else if (beat_done) begin
        addr_q       <= addr_q + AddrStep;
        beats_left_q <= beats_left_q - 8'd1;
        first_q      <= 1'b0;
      end
    end
  end

`ifdef IDMA_OBI_WRITE_ERR_EN
  // Sticky burst error, cleared when the next descriptor is accepted.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      err_q <= 1'b0;
    end else if (desc_take) begin
      err_q <= 1'b0;
    end else if (obi_rvalid_i && obi_err_i && ((state_q == BURST) || (state_q == DRAIN))) begin
      err_q <= 1'b1;
    end
  end
`else
  logic unused_err;
  assign unused_err = obi_err_i;
  assign err_q      = 1'b0;
`endif

  // A response with nothing outstanding means the bus and the counter disagree.
  assert property (@(posedge clk_i) disable iff (rst_i)
    obi_rvalid_i |-> (outstanding_q != '0));

endmodule

// File: tb/tb_idma_obi_write_burst_issuer.sv
// tb_idma_obi_write_burst_issuer
// Bench for the OBI write burst issuer: an OBI subordinate and a data source
// are modelled per cycle, every granted beat is logged, and each scenario task
// compares the log against addresses, byte enables and timing derived from the
// burst description with plain arithmetic.
module tb_idma_obi_write_burst_issuer;

  localparam int MAX_OUT = 2;
`ifdef IDMA_OBI_WRITE_ERR_EN
  localparam bit ERR_EN = 1'b1;
`else
  localparam bit ERR_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_i;
  logic [31:0] req_addr_i;
  logic [7:0]  req_num_beats_i;
  logic [1:0]  req_offset_i, req_tailer_i;
  logic        req_last_i, req_valid_i, req_ready_o;
  logic [31:0] data_i;
  logic        data_valid_i, data_ready_o;
  logic        obi_req_o, obi_we_o;
  logic [31:0] obi_addr_o;
  logic [3:0]  obi_be_o;
  logic [31:0] obi_wdata_o;
  logic        obi_gnt_i, obi_rvalid_i, obi_err_i;
  logic        rsp_valid_o, rsp_ready_i, rsp_last_o, rsp_err_o, busy_o;

  always #5 clk = ~clk;

  idma_obi_write_burst_issuer #(
    .DataWidth(32), .AddrWidth(32), .MaxOutstanding(MAX_OUT)
  ) dut (
    .clk_i(clk), .rst_i(rst_i),
    .req_addr_i(req_addr_i), .req_num_beats_i(req_num_beats_i),
    .req_offset_i(req_offset_i), .req_tailer_i(req_tailer_i),
    .req_last_i(req_last_i), .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
    .data_i(data_i), .data_valid_i(data_valid_i), .data_ready_o(data_ready_o),
    .obi_req_o(obi_req_o), .obi_we_o(obi_we_o), .obi_addr_o(obi_addr_o),
    .obi_be_o(obi_be_o), .obi_wdata_o(obi_wdata_o),
    .obi_gnt_i(obi_gnt_i), .obi_rvalid_i(obi_rvalid_i), .obi_err_i(obi_err_i),
    .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready_i),
    .rsp_last_o(rsp_last_o), .rsp_err_o(rsp_err_o), .busy_o(busy_o)
  );

  int errors = 0;
  int checks = 0;
  int cyc = 0;

  // Descriptor and environment knobs
  bit          desc_pending;
  logic [31:0] d_addr;
  int          d_nb, d_off, d_tail, err_beat;
  bit          d_last;
  int          gnt_mode, stall_beat, stall_left, valid_prob, lat_min, lat_max, rdy_prob;

  // Data source, outstanding responses and observation log
  logic [31:0] data_q[$];
  logic [31:0] sent_q[$];
  int          due_q[$];
  bit          perr_q[$];
  logic [31:0] log_addr[$];
  logic [31:0] log_wdata[$];
  logic [3:0]  log_be[$];
  int          log_cyc[$];

  bit          in_burst, hold_valid, prev_stall, rsp_done, got_last, got_err;
  int          beats_granted, accept_cyc, first_rsp_cyc, last_rvalid_cyc;
  int          req_viol, rdy_viol, stab_viol, stall_seen;
  logic [31:0] prev_addr, prev_wdata;
  logic [3:0]  prev_be;

  // Lane i of beat b is written when it is at/after the offset on the first
  // beat and before the tailer on the last beat (tailer 0 = whole word).
  function automatic logic [3:0] model_be(int beat, int nb, int off, int tail);
    logic [3:0] m;
    m = '0;
    for (int j = 0; j < 4; j++)
      if (((beat != 0) || (j >= off)) && ((beat != nb) || (tail == 0) || (j < tail)))
        m[j] = 1'b1;
    return m;
  endfunction

  function automatic logic [31:0] model_addr(logic [31:0] base, int beat);
    return (base & 32'hFFFF_FFFC) + 32'(4 * beat);
  endfunction

  // One clock cycle: drive inputs on the falling edge, observe, then advance.
  task automatic step();
    bit exp_req;
    @(negedge clk);
    if (hold_valid) data_valid_i = 1'b1;
    else data_valid_i = (data_q.size() > 0) && (int'($urandom_range(0, 99)) < valid_prob);
    data_i          = (data_q.size() > 0) ? data_q[0] : 32'h0;
    req_valid_i     = desc_pending;
    req_addr_i      = d_addr;
    req_num_beats_i = 8'(d_nb);
    req_offset_i    = 2'(d_off);
    req_tailer_i    = 2'(d_tail);
    req_last_i      = d_last;
    case (gnt_mode)
      0:       obi_gnt_i = 1'b1;
      1:       obi_gnt_i = (int'($urandom_range(0, 99)) < 60);
      default: obi_gnt_i = !((beats_granted == stall_beat) && (stall_left > 0));
    endcase
    if (due_q.size() > 0 && due_q[0] <= cyc) begin
      obi_rvalid_i = 1'b1;
      obi_err_i    = perr_q[0];
    end else begin
      obi_rvalid_i = 1'b0;
      obi_err_i    = 1'($urandom_range(0, 1));
    end
    rsp_ready_i = (int'($urandom_range(0, 99)) < rdy_prob);
    #1;
    exp_req = in_burst && data_valid_i && (due_q.size() < MAX_OUT);
    if (obi_req_o !== exp_req) req_viol++;
    if (data_ready_o !== (exp_req && obi_gnt_i)) rdy_viol++;
    if (prev_stall && (obi_req_o !== 1'b1 || obi_addr_o !== prev_addr ||
                       obi_be_o !== prev_be || obi_wdata_o !== prev_wdata)) stab_viol++;
    if (gnt_mode == 2 && obi_req_o === 1'b1 && !obi_gnt_i) begin
      stall_seen++;
      if (stall_left > 0) stall_left--;
    end
    if (obi_rvalid_i) begin
      void'(due_q.pop_front());
      void'(perr_q.pop_front());
      last_rvalid_cyc = cyc;
    end
    if (obi_req_o === 1'b1 && obi_gnt_i) begin
      log_addr.push_back(obi_addr_o);
      log_be.push_back(obi_be_o);
      log_wdata.push_back(obi_wdata_o);
      log_cyc.push_back(cyc);
      if (data_q.size() > 0) void'(data_q.pop_front());
      due_q.push_back(cyc + int'($urandom_range(lat_min, lat_max)));
      perr_q.push_back(beats_granted == err_beat);
      beats_granted++;
      if (beats_granted > d_nb) in_burst = 1'b0;
    end
    hold_valid = data_valid_i && (data_ready_o !== 1'b1) && (data_q.size() > 0);
    prev_stall = (obi_req_o === 1'b1) && !obi_gnt_i;
    prev_addr  = obi_addr_o;
    prev_be    = obi_be_o;
    prev_wdata = obi_wdata_o;
    if (rsp_valid_o === 1'b1 && first_rsp_cyc < 0) first_rsp_cyc = cyc;
    if (rsp_valid_o === 1'b1 && rsp_ready_i && !rsp_done) begin
      rsp_done = 1'b1;
      got_last = rsp_last_o;
      got_err  = rsp_err_o;
    end
    if (req_valid_i && req_ready_o === 1'b1) begin
      desc_pending = 1'b0;
      in_burst     = 1'b1;
      accept_cyc   = cyc;
    end
    @(posedge clk);
    cyc++;
  endtask

  task automatic start_burst(input logic [31:0] addr, input int nb, input int off,
                             input int tail, input bit last, input int eb);
    logic [31:0] w;
    d_addr = addr; d_nb = nb; d_off = off; d_tail = tail; d_last = last; err_beat = eb;
    desc_pending = 1'b1;
    data_q.delete(); sent_q.delete();
    for (int i = 0; i <= nb; i++) begin
      w = $urandom;
      data_q.push_back(w);
      sent_q.push_back(w);
    end
    log_addr.delete(); log_be.delete(); log_wdata.delete(); log_cyc.delete();
    beats_granted = 0; in_burst = 1'b0; rsp_done = 1'b0;
    got_last = 1'b0; got_err = 1'b0;
    accept_cyc = -1; first_rsp_cyc = -1; last_rvalid_cyc = -1;
    req_viol = 0; rdy_viol = 0; stab_viol = 0; stall_seen = 0;
  endtask

  task automatic run_burst(input logic [31:0] addr, input int nb, input int off,
                           input int tail, input bit last, input int eb);
    start_burst(addr, nb, off, tail, last, eb);
    for (int n = 0; n < 400 && !rsp_done; n++) step();
    checks++;
    if (!rsp_done) begin
      errors++;
      $display("[TB] FAIL burst_timeout: actual rsp_done=0 required 1 (addr %h)", addr);
    end
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst_i = 1'b1;
    repeat (2) begin @(posedge clk); cyc++; end
    @(negedge clk);
    rst_i = 1'b0;
    data_valid_i = 1'b1;
    #1;
    checks += 9;
    if (req_ready_o !== 1'b1) begin errors++; $display("[TB] FAIL reset_req_ready: actual %b required 1", req_ready_o); end
    if (obi_req_o !== 1'b0) begin errors++; $display("[TB] FAIL reset_obi_req: actual %b required 0", obi_req_o); end
    if (busy_o !== 1'b0) begin errors++; $display("[TB] FAIL reset_busy: actual %b required 0", busy_o); end
    if (rsp_valid_o !== 1'b0) begin errors++; $display("[TB] FAIL reset_rsp_valid: actual %b required 0", rsp_valid_o); end
    if (data_ready_o !== 1'b0) begin errors++; $display("[TB] FAIL reset_data_ready: actual %b required 0", data_ready_o); end
    if (obi_be_o !== 4'b0000) begin errors++; $display("[TB] FAIL reset_be: actual %b required 0000", obi_be_o); end
    if (obi_addr_o !== 32'h0) begin errors++; $display("[TB] FAIL reset_addr: actual %h required 0", obi_addr_o); end
    if (rsp_last_o !== 1'b0) begin errors++; $display("[TB] FAIL reset_rsp_last: actual %b required 0", rsp_last_o); end
    if (rsp_err_o !== 1'b0) begin errors++; $display("[TB] FAIL reset_rsp_err: actual %b required 0", rsp_err_o); end
    @(posedge clk);
    cyc++;
    data_valid_i = 1'b0;
  endtask

  task automatic test_single_beat();
    gnt_mode = 0; valid_prob = 100; lat_min = 2; lat_max = 2; rdy_prob = 100;
    run_burst(32'h0000_1003, 0, 1, 3, 1'b1, -1);
    checks += 8;
    if (log_addr.size() != 1) begin errors++; $display("[TB] FAIL single_count: actual %0d required 1", log_addr.size()); end
    if (log_addr[0] !== 32'h0000_1000) begin errors++; $display("[TB] FAIL single_addr: actual %h required 00001000", log_addr[0]); end
    if (log_be[0] !== 4'b0110) begin errors++; $display("[TB] FAIL single_be: actual %b required 0110", log_be[0]); end
    if (log_wdata[0] !== sent_q[0]) begin errors++; $display("[TB] FAIL single_wdata: actual %h required %h", log_wdata[0], sent_q[0]); end
    if (log_cyc[0] != accept_cyc + 1) begin errors++; $display("[TB] FAIL single_first_req: actual cycle %0d required %0d", log_cyc[0], accept_cyc + 1); end
    if (first_rsp_cyc != log_cyc[0] + 3) begin errors++; $display("[TB] FAIL single_rsp_latency: actual cycle %0d required %0d", first_rsp_cyc, log_cyc[0] + 3); end
    if (got_last !== 1'b1) begin errors++; $display("[TB] FAIL single_last: actual %b required 1", got_last); end
    if (req_viol != 0) begin errors++; $display("[TB] FAIL single_req_rule: actual %0d bad cycles required 0", req_viol); end
  endtask

  task automatic test_four_beats();
    gnt_mode = 0; valid_prob = 100; lat_min = 1; lat_max = 1; rdy_prob = 100;
    run_burst(32'h0000_0100, 3, 2, 0, 1'b0, -1);
    checks += 2;
    if (log_addr.size() != 4) begin errors++; $display("[TB] FAIL four_count: actual %0d required 4", log_addr.size()); end
    if (got_last !== 1'b0) begin errors++; $display("[TB] FAIL four_last: actual %b required 0", got_last); end
    for (int i = 0; i < 4; i++) begin
      logic [3:0] eb;
      eb = (i == 0) ? 4'b1100 : 4'b1111;
      checks += 3;
      if (log_addr[i] !== 32'h100 + 32'(4 * i)) begin errors++; $display("[TB] FAIL four_addr[%0d]: actual %h required %h", i, log_addr[i], 32'h100 + 32'(4 * i)); end
      if (log_be[i] !== eb) begin errors++; $display("[TB] FAIL four_be[%0d]: actual %b required %b", i, log_be[i], eb); end
      if (log_cyc[i] != log_cyc[0] + i) begin errors++; $display("[TB] FAIL four_cycle[%0d]: actual %0d required %0d", i, log_cyc[i], log_cyc[0] + i); end
    end
  endtask

  task automatic test_gnt_stall();
    gnt_mode = 2; valid_prob = 100; lat_min = 1; lat_max = 1; rdy_prob = 100;
    stall_beat = 1; stall_left = 3;
    start_burst(32'h0000_2000, 2, 0, 0, 1'b1, -1);
    stall_beat = 1; stall_left = 3;
    for (int n = 0; n < 400 && !rsp_done; n++) step();
    checks += 6;
    if (!rsp_done) begin errors++; $display("[TB] FAIL stall_timeout: actual rsp_done=0 required 1"); end
    if (stall_seen != 3) begin errors++; $display("[TB] FAIL stall_cycles: actual %0d required 3", stall_seen); end
    if (stab_viol != 0) begin errors++; $display("[TB] FAIL stall_stability: actual %0d unstable cycles required 0", stab_viol); end
    if (rdy_viol != 0) begin errors++; $display("[TB] FAIL stall_data_ready: actual %0d bad cycles required 0", rdy_viol); end
    if (log_cyc[1] - log_cyc[0] != 4) begin errors++; $display("[TB] FAIL stall_gap: actual %0d required 4", log_cyc[1] - log_cyc[0]); end
    if (log_wdata[1] !== sent_q[1]) begin errors++; $display("[TB] FAIL stall_wdata: actual %h required %h", log_wdata[1], sent_q[1]); end
    gnt_mode = 0;
  endtask

  task automatic test_outstanding_limit();
    gnt_mode = 0; valid_prob = 100; lat_min = 5; lat_max = 5; rdy_prob = 100;
    run_burst(32'h0000_0200, 3, 0, 0, 1'b1, -1);
    checks += 5;
    if (log_cyc[1] - log_cyc[0] != 1) begin errors++; $display("[TB] FAIL limit_second: actual gap %0d required 1", log_cyc[1] - log_cyc[0]); end
    if (log_cyc[2] - log_cyc[0] != 6) begin errors++; $display("[TB] FAIL limit_third: actual gap %0d required 6", log_cyc[2] - log_cyc[0]); end
    if (log_cyc[3] - log_cyc[0] != 7) begin errors++; $display("[TB] FAIL limit_fourth: actual gap %0d required 7", log_cyc[3] - log_cyc[0]); end
    if (first_rsp_cyc != last_rvalid_cyc + 1) begin errors++; $display("[TB] FAIL limit_rsp: actual cycle %0d required %0d", first_rsp_cyc, last_rvalid_cyc + 1); end
    if (req_viol != 0) begin errors++; $display("[TB] FAIL limit_req_rule: actual %0d bad cycles required 0", req_viol); end
  endtask

  task automatic test_error();
    gnt_mode = 0; valid_prob = 100; lat_min = 2; lat_max = 2; rdy_prob = 100;
    run_burst(32'h0000_3000, 2, 0, 0, 1'b1, 1);
    checks++;
    if (got_err !== ERR_EN) begin errors++; $display("[TB] FAIL err_flag: actual %b required %b", got_err, ERR_EN); end
    run_burst(32'h0000_3100, 1, 0, 0, 1'b0, -1);
    checks += 2;
    if (got_err !== 1'b0) begin errors++; $display("[TB] FAIL err_cleared: actual %b required 0", got_err); end
    if (got_last !== 1'b0) begin errors++; $display("[TB] FAIL err_next_last: actual %b required 0", got_last); end
  endtask

  task automatic test_reset_mid_burst();
    gnt_mode = 0; valid_prob = 100; lat_min = 3; lat_max = 3; rdy_prob = 100;
    start_burst(32'h0000_0400, 3, 0, 0, 1'b1, -1);
    for (int n = 0; n < 50 && beats_granted < 1; n++) step();
    @(negedge clk);
    rst_i = 1'b1; data_valid_i = 1'b1; obi_gnt_i = 1'b0; obi_rvalid_i = 1'b0; req_valid_i = 1'b0;
    @(posedge clk);
    cyc++;
    @(negedge clk);
    rst_i = 1'b0; data_valid_i = 1'b1; obi_gnt_i = 1'b1;
    #1;
    checks += 4;
    if (beats_granted != 1) begin errors++; $display("[TB] FAIL rst_setup_beats: actual %0d required 1", beats_granted); end
    if (obi_req_o !== 1'b0) begin errors++; $display("[TB] FAIL rst_mid_req: actual %b required 0", obi_req_o); end
    if (busy_o !== 1'b0) begin errors++; $display("[TB] FAIL rst_mid_busy: actual %b required 0", busy_o); end
    if (req_ready_o !== 1'b1) begin errors++; $display("[TB] FAIL rst_mid_req_ready: actual %b required 1", req_ready_o); end
    @(posedge clk);
    cyc++;
    due_q.delete(); perr_q.delete(); data_q.delete();
    in_burst = 1'b0; hold_valid = 1'b0; prev_stall = 1'b0; desc_pending = 1'b0;
    run_burst(32'h0000_0800, 1, 0, 0, 1'b1, -1);
    checks += 3;
    if (log_addr.size() != 2) begin errors++; $display("[TB] FAIL rst_new_count: actual %0d required 2", log_addr.size()); end
    if (log_addr[0] !== 32'h0000_0800) begin errors++; $display("[TB] FAIL rst_new_addr: actual %h required 00000800", log_addr[0]); end
    if (got_last !== 1'b1) begin errors++; $display("[TB] FAIL rst_new_last: actual %b required 1", got_last); end
  endtask

  task automatic test_random();
    for (int k = 0; k < 25; k++) begin
      logic [31:0] a;
      int nb, off, tail, eb;
      bit last;
      gnt_mode = 1; valid_prob = 70; lat_min = 1; lat_max = 4; rdy_prob = 50;
      a    = (k % 5 == 0) ? (32'hFFFF_FFF0 | ($urandom & 32'hF)) : $urandom;
      nb   = int'($urandom_range(0, 6));
      off  = int'($urandom_range(0, 3));
      tail = int'($urandom_range(0, 3));
      if (nb == 0 && tail != 0 && tail <= off) tail = 0;
      last = 1'($urandom_range(0, 1));
      eb   = int'($urandom_range(0, nb + 1)) - 1;
      run_burst(a, nb, off, tail, last, eb);
      checks += 4;
      if (log_addr.size() != nb + 1) begin errors++; $display("[TB] FAIL rand%0d_count: actual %0d required %0d", k, log_addr.size(), nb + 1); end
      if (got_last !== last) begin errors++; $display("[TB] FAIL rand%0d_last: actual %b required %b", k, got_last, last); end
      if (got_err !== (ERR_EN && eb >= 0)) begin errors++; $display("[TB] FAIL rand%0d_err: actual %b required %b", k, got_err, ERR_EN && eb >= 0); end
      if (req_viol + rdy_viol + stab_viol != 0 || first_rsp_cyc != last_rvalid_cyc + 1) begin
        errors++;
        $display("[TB] FAIL rand%0d_protocol: actual req=%0d rdy=%0d stab=%0d rsp@%0d required 0/0/0 rsp@%0d",
                 k, req_viol, rdy_viol, stab_viol, first_rsp_cyc, last_rvalid_cyc + 1);
      end
      for (int i = 0; i < log_addr.size() && i <= nb; i++) begin
        checks++;
        if (log_addr[i] !== model_addr(a, i) || log_be[i] !== model_be(i, nb, off, tail) ||
            log_wdata[i] !== sent_q[i]) begin
          errors++;
          $display("[TB] FAIL rand%0d_beat%0d: actual %h/%b/%h required %h/%b/%h", k, i,
                   log_addr[i], log_be[i], log_wdata[i],
                   model_addr(a, i), model_be(i, nb, off, tail), sent_q[i]);
        end
      end
    end
  endtask

  initial begin
    rst_i = 1'b1; req_addr_i = '0; req_num_beats_i = '0; req_offset_i = '0; req_tailer_i = '0;
    req_last_i = 1'b0; req_valid_i = 1'b0; data_i = '0; data_valid_i = 1'b0;
    obi_gnt_i = 1'b0; obi_rvalid_i = 1'b0; obi_err_i = 1'b0; rsp_ready_i = 1'b0;
    desc_pending = 1'b0; d_addr = '0; d_nb = 0; d_off = 0; d_tail = 0; d_last = 1'b0; err_beat = -1;
    gnt_mode = 0; stall_beat = -1; stall_left = 0; valid_prob = 100;
    lat_min = 1; lat_max = 1; rdy_prob = 100;
    in_burst = 1'b0; hold_valid = 1'b0; prev_stall = 1'b0; beats_granted = 0;
    prev_addr = '0; prev_be = '0; prev_wdata = '0;
    $display("[TB] starting idma_obi_write_burst_issuer bench (ERR_EN=%0b)", ERR_EN);
    test_reset();
    test_single_beat();
    test_four_beats();
    test_gnt_stall();
    test_outstanding_limit();
    test_error();
    test_reset_mid_burst();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
